// File: rtl/bit_serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_pkg;

  // Bits per frame when the top is not overridden.
  localparam int DEFAULT_WIDTH = 8;

  // Width of the in-frame bit counter for the default frame size.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Counter width for an arbitrary frame size; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Serial operand/result bundle between a bit source and the subtractor.
// Latency: n/a (wires only).
// Backpressure: none; the consumer is always ready.
interface bit_serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             a_in;
  logic             b_in;
  logic             in_last;
  logic             diff_out;
  logic             diff_valid;
  logic [WIDTH-1:0] word_out;
  logic             borrow_out;
  logic             word_valid;
  logic             frame_err;

  // Bit source side.
  modport master (
    output in_valid, a_in, b_in, in_last,
    input  diff_out, diff_valid, word_out, borrow_out, word_valid, frame_err
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a_in, b_in, in_last,
    output diff_out, diff_valid, word_out, borrow_out, word_valid, frame_err
  );

endinterface

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor with a registered borrow carried between bits.
// Latency: d/br_next are combinational; borrow is stored on each enabled edge.
// Backpressure: none; en simply gates the borrow update.
module serial_sub_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr_br,
  input  logic a,
  input  logic b,
  output logic d,
  output logic br_next
);

  logic br_q;
  logic br_eff;

  // Bit 0 of a frame must see no incoming borrow, regardless of what the
  // previous (good, errored or partial) frame left behind.
  assign br_eff  = br_q & ~clr_br;
  assign d       = a ^ b ^ br_eff;
  assign br_next = (~a & b) | (~(a ^ b) & br_eff);

  // Borrow register advances only on accepted bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= 1'b0;
    end else if (en) begin
      br_q <= br_next;
    end
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial A-B with per-bit output and framed parallel result.
// Latency: 1 cycle for diff_out; word_valid/frame_err 1 cycle after last bit.
// Backpressure: none; a bit is consumed on every edge with in_valid high.
module bit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  bit_serial_subtractor_if.slave  bus
);

  localparam int              BCW      = cnt_width(WIDTH);
  localparam logic [BCW-1:0]  LAST_IDX = BCW'(WIDTH - 1);

  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             accept;
  logic             at_last;
  logic             frame_end;
  logic             good;
  logic             bad;
  logic             d;
  logic             br_next;

  logic             diff_q;
  logic             diff_vld_q;
  logic [WIDTH-1:0] word_q;
  logic             borrow_q;
  logic             word_vld_q;
  logic             err_q;

  // Frame position is carried entirely by bit_cnt: a frame closes either on
  // a correct last, an early last, or reaching the final slot without last.
  assign accept    = bus.in_valid;
  assign at_last   = (bit_cnt == LAST_IDX);
  assign frame_end = accept & (at_last | bus.in_last);
  assign good      = accept & at_last & bus.in_last;
  assign bad       = accept & (at_last ^ bus.in_last);
  assign sreg_next = {d, sreg[WIDTH-1:1]};

  serial_sub_cell u_cell (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .clr_br  (bit_cnt == '0),
    .a       (bus.a_in),
    .b       (bus.b_in),
    .d       (d),
    .br_next (br_next)
  );

  // Bit position within the frame; any frame close returns it to bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
    end
  end

  // Difference bits enter at the MSB so bit 0 holds the LSB after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= sreg_next;
    end
  end

  // Serial result: one valid bit per accepted input, value held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= 1'b0;
      diff_vld_q <= 1'b0;
    end else begin
      diff_vld_q <= accept;
      if (accept) begin
        diff_q <= d;
      end
    end
  end

  // Parallel result updates only on a good frame; errors just pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      borrow_q   <= 1'b0;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      word_vld_q <= good;
      err_q      <= bad;
      if (good) begin
        word_q   <= sreg_next;
        borrow_q <= br_next;
      end
    end
  end

  assign bus.diff_out   = diff_q;
  assign bus.diff_valid = diff_vld_q;
  assign bus.word_out   = word_q;
  assign bus.borrow_out = borrow_q;
  assign bus.word_valid = word_vld_q;
  assign bus.frame_err  = err_q;

endmodule
